// File: rtl/gt_init_pkg.sv
// Shared types and helpers for the GT link bring-up sequencer.
// Holds the sequencer state encoding, retry counter sizing and timer sizing.
package gt_init_pkg;

  typedef enum logic [2:0] {
    RST_ALL   = 3'd0,
    WAIT_RST  = 3'd1,
    WAIT_BB   = 3'd2,
    WAIT_LINK = 3'd3,
    DONE      = 3'd4,
    RST_RX    = 3'd5,
    RETRY     = 3'd6,
    FAIL      = 3'd7
  } gt_init_state_e;

  localparam int C_RETRY_W = 4;
  localparam logic [C_RETRY_W-1:0] C_RETRY_MAX = 4'hF;

  // One timer serves both pulse and timeout counting, so size it for the larger.
  function automatic int timer_width(input int timeout_cyc, input int pulse_cyc);
    int max_v;
    max_v = (timeout_cyc > pulse_cyc) ? timeout_cyc : pulse_cyc;
    return $clog2(max_v + 1);
  endfunction

  function automatic logic [C_RETRY_W-1:0] retry_sat_inc(input logic [C_RETRY_W-1:0] v);
    if (v == C_RETRY_MAX) begin
      return v;
    end else begin
      return v + 4'd1;
    end
  endfunction

endpackage

// File: rtl/gt_link_init_sequencer_if.sv
// GT channel status/reset-request bundle between the bring-up sequencer and the GT wrapper.
// master = sequencer side, slave = transceiver/debug side.
interface gt_link_init_sequencer_if;
  import gt_init_pkg::*;

  logic                 gtwiz_reset_tx_done_sync;
  logic                 gtwiz_reset_rx_done_sync;
  logic                 gtwiz_buffbypass_rx_done_sync;
  logic                 gtwiz_buffbypass_rx_error_sync;
  logic                 link_status_in;
  logic                 link_down_latched_reset_in;
  logic                 gtwiz_reset_all_init_int;
  logic                 gtwiz_reset_rx_datapath_init_int;
  logic                 init_done_int;
  logic [C_RETRY_W-1:0] init_retry_ctr_int;
  logic                 link_down_latched_out;
  logic                 init_fail_out;

  modport master (
    input  gtwiz_reset_tx_done_sync,
    input  gtwiz_reset_rx_done_sync,
    input  gtwiz_buffbypass_rx_done_sync,
    input  gtwiz_buffbypass_rx_error_sync,
    input  link_status_in,
    input  link_down_latched_reset_in,
    output gtwiz_reset_all_init_int,
    output gtwiz_reset_rx_datapath_init_int,
    output init_done_int,
    output init_retry_ctr_int,
    output link_down_latched_out,
    output init_fail_out
  );

  modport slave (
    output gtwiz_reset_tx_done_sync,
    output gtwiz_reset_rx_done_sync,
    output gtwiz_buffbypass_rx_done_sync,
    output gtwiz_buffbypass_rx_error_sync,
    output link_status_in,
    output link_down_latched_reset_in,
    input  gtwiz_reset_all_init_int,
    input  gtwiz_reset_rx_datapath_init_int,
    input  init_done_int,
    input  init_retry_ctr_int,
    input  link_down_latched_out,
    input  init_fail_out
  );

endinterface

// File: rtl/gt_init_timer.sv
// Loadable down-counter used for reset pulse lengths and WAIT_* timeouts.
// Stops at zero; expired is high while the count is zero.
module gt_init_timer #(
  parameter int               P_W       = 8,
  parameter logic [P_W-1:0]   P_RST_VAL = {P_W{1'b0}}
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [P_W-1:0] load_val,
  input  logic           en,
  output logic           expired
);

  logic [P_W-1:0] cnt_r;

  // Count register: reset value, reload, or decrement towards zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= P_RST_VAL;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != {P_W{1'b0}})) begin
      cnt_r <= cnt_r - P_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == {P_W{1'b0}});

endmodule

// File: rtl/gt_link_init_sequencer.sv
// Autonomous bring-up sequencer for one GT channel (free-running clock domain).
// Define GT_INIT_AUTO_RETRY_EN to loop failures back to reset_all instead of a terminal FAIL.
module gt_link_init_sequencer
  import gt_init_pkg::*;
#(
  parameter int P_RST_PULSE_CYC    = 16,
  parameter int P_WAIT_TIMEOUT_CYC = 12_500_000,
  parameter int P_LINK_STABLE_CYC  = 1024
) (
  input  logic                            hb_gtwiz_reset_clk_freerun_buf_int,
  input  logic                            hb_gtwiz_reset_all_int,
  gt_link_init_sequencer_if.master        gt
);

  localparam int C_TMR_W = timer_width(P_WAIT_TIMEOUT_CYC, P_RST_PULSE_CYC);
  localparam int C_STB_W = $clog2(P_LINK_STABLE_CYC + 1);
  localparam logic [C_TMR_W-1:0] C_PULSE_LOAD = C_TMR_W'(P_RST_PULSE_CYC - 1);
  localparam logic [C_TMR_W-1:0] C_WAIT_LOAD  = C_TMR_W'(P_WAIT_TIMEOUT_CYC);
  localparam logic [C_STB_W-1:0] C_STB_LAST   = C_STB_W'(P_LINK_STABLE_CYC - 1);

  gt_init_state_e        state_r;
  gt_init_state_e        nxt_state_s;
  logic [C_STB_W-1:0]    stable_r;
  logic [C_RETRY_W-1:0]  retry_ctr_r;
  logic                  reset_all_r;
  logic                  rx_datapath_r;
  logic                  init_done_r;
  logic                  link_down_latched_r;
  logic                  init_fail_r;
  logic                  tx_done_d_r;
  logic                  rx_done_d_r;
  logic                  tx_fall_s;
  logic                  rx_fall_s;
  logic                  tmr_load_s;
  logic                  tmr_en_s;
  logic [C_TMR_W-1:0]    tmr_val_s;
  logic                  tmr_expired_s;

  assign tx_fall_s = tx_done_d_r & ~gt.gtwiz_reset_tx_done_sync;
  assign rx_fall_s = rx_done_d_r & ~gt.gtwiz_reset_rx_done_sync;

  gt_init_timer #(
    .P_W       (C_TMR_W),
    .P_RST_VAL (C_PULSE_LOAD)
  ) u_timer (
    .clk      (hb_gtwiz_reset_clk_freerun_buf_int),
    .rst      (hb_gtwiz_reset_all_int),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .en       (tmr_en_s),
    .expired  (tmr_expired_s)
  );

  // Next-state decode; a done condition is checked before timer expiry so it wins.
  always_comb begin
    nxt_state_s = state_r;
    case (state_r)
      RST_ALL: begin
        if (tmr_expired_s) nxt_state_s = WAIT_RST;
        else               nxt_state_s = RST_ALL;
      end
      WAIT_RST: begin
        if (gt.gtwiz_reset_tx_done_sync && gt.gtwiz_reset_rx_done_sync) nxt_state_s = WAIT_BB;
        else if (tmr_expired_s)                                         nxt_state_s = RETRY;
        else                                                            nxt_state_s = WAIT_RST;
      end
      WAIT_BB: begin
        if (gt.gtwiz_buffbypass_rx_error_sync)     nxt_state_s = RETRY;
        else if (gt.gtwiz_buffbypass_rx_done_sync) nxt_state_s = WAIT_LINK;
        else if (tmr_expired_s)                    nxt_state_s = RETRY;
        else                                       nxt_state_s = WAIT_BB;
      end
      WAIT_LINK: begin
        if (gt.link_status_in && (stable_r == C_STB_LAST)) nxt_state_s = DONE;
        else if (tmr_expired_s)                            nxt_state_s = RETRY;
        else                                               nxt_state_s = WAIT_LINK;
      end
      DONE: begin
        if (!gt.link_status_in)       nxt_state_s = RST_RX;
        else if (tx_fall_s || rx_fall_s) nxt_state_s = RETRY;
        else                          nxt_state_s = DONE;
      end
      RST_RX: begin
        if (tmr_expired_s) nxt_state_s = WAIT_RST;
        else               nxt_state_s = RST_RX;
      end
      RETRY: begin
`ifdef GT_INIT_AUTO_RETRY_EN
        nxt_state_s = RST_ALL;
`else
        nxt_state_s = FAIL;
`endif
      end
      FAIL: begin
        nxt_state_s = FAIL;
      end
      default: begin
        nxt_state_s = RST_ALL;
      end
    endcase
  end

  // Timer control: reload on every state change, count down while staying.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_en_s   = 1'b0;
    tmr_val_s  = C_WAIT_LOAD;
    if (nxt_state_s != state_r) begin
      tmr_load_s = 1'b1;
      if ((nxt_state_s == RST_ALL) || (nxt_state_s == RST_RX)) begin
        tmr_val_s = C_PULSE_LOAD;
      end else begin
        tmr_val_s = C_WAIT_LOAD;
      end
    end else begin
      tmr_en_s = 1'b1;
    end
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge hb_gtwiz_reset_clk_freerun_buf_int) begin
    if (hb_gtwiz_reset_all_int) begin
      state_r             <= RST_ALL;
      stable_r            <= {C_STB_W{1'b0}};
      retry_ctr_r         <= {C_RETRY_W{1'b0}};
      reset_all_r         <= 1'b1;
      rx_datapath_r       <= 1'b0;
      init_done_r         <= 1'b0;
      link_down_latched_r <= 1'b0;
      init_fail_r         <= 1'b0;
      tx_done_d_r         <= 1'b0;
      rx_done_d_r         <= 1'b0;
    end else begin
      state_r       <= nxt_state_s;
      reset_all_r   <= (nxt_state_s == RST_ALL);
      rx_datapath_r <= (nxt_state_s == RST_RX);
      init_done_r   <= (nxt_state_s == DONE);
`ifdef GT_INIT_AUTO_RETRY_EN
      init_fail_r   <= 1'b0;
`else
      init_fail_r   <= (nxt_state_s == FAIL);
`endif
      tx_done_d_r   <= gt.gtwiz_reset_tx_done_sync;
      rx_done_d_r   <= gt.gtwiz_reset_rx_done_sync;

      if (state_r == WAIT_LINK) begin
        if (gt.link_status_in) stable_r <= stable_r + C_STB_W'(1);
        else                   stable_r <= {C_STB_W{1'b0}};
      end else begin
        stable_r <= {C_STB_W{1'b0}};
      end

      if (state_r == RETRY) retry_ctr_r <= retry_sat_inc(retry_ctr_r);
      else                  retry_ctr_r <= retry_ctr_r;

      // A fresh link loss overrides a simultaneous clear request.
      if ((state_r == DONE) && !gt.link_status_in) link_down_latched_r <= 1'b1;
      else if (gt.link_down_latched_reset_in)      link_down_latched_r <= 1'b0;
      else                                         link_down_latched_r <= link_down_latched_r;
    end
  end

  assign gt.gtwiz_reset_all_init_int         = reset_all_r;
  assign gt.gtwiz_reset_rx_datapath_init_int = rx_datapath_r;
  assign gt.init_done_int                    = init_done_r;
  assign gt.init_retry_ctr_int               = retry_ctr_r;
  assign gt.link_down_latched_out            = link_down_latched_r;
  assign gt.init_fail_out                    = init_fail_r;

endmodule

// File: tb/tb_gt_link_init_sequencer.sv
// Scoreboard bench for gt_link_init_sequencer: expected output snapshots are queued with
// their cycle stamps; a monitor checks them and flags any output change not announced.
module tb_gt_link_init_sequencer;

  localparam int P_PULSE = 4;
  localparam int P_WAIT  = 100;
  localparam int P_STB   = 8;
  // reset_all pulse + WAIT_RST (load P_WAIT, expire at 0) + one RETRY cycle
  localparam int C_RETRY_PERIOD = P_PULSE + P_WAIT + 2;

  typedef struct packed {
    logic       reset_all;
    logic       rx_dp;
    logic       init_done;
    logic [3:0] ctr;
    logic       latched;
    logic       fail;
  } outs_t;

  typedef struct {
    int    cyc;
    outs_t v;
    string nm;
  } exp_t;

  logic  clk;
  logic  rst;
  int    cyc;
  int    base;
  int    n_checks;
  int    n_fail;
  logic  mon_en;
  outs_t prev_v;
  outs_t e;
  exp_t  exp_q[$];

  gt_link_init_sequencer_if gt_if ();

  gt_link_init_sequencer #(
    .P_RST_PULSE_CYC    (P_PULSE),
    .P_WAIT_TIMEOUT_CYC (P_WAIT),
    .P_LINK_STABLE_CYC  (P_STB)
  ) dut (
    .hb_gtwiz_reset_clk_freerun_buf_int (clk),
    .hb_gtwiz_reset_all_int             (rst),
    .gt                                 (gt_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop expectations stamped for this cycle; any other output change is an error.
  always @(negedge clk) begin
    outs_t cur;
    exp_t  x;
    cur = {gt_if.gtwiz_reset_all_init_int, gt_if.gtwiz_reset_rx_datapath_init_int,
           gt_if.init_done_int, gt_if.init_retry_ctr_int, gt_if.link_down_latched_out,
           gt_if.init_fail_out};
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        x = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", x.nm, x.cyc, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        x = exp_q.pop_front();
        n_checks++;
        if (cur !== x.v) begin
          n_fail++;
          $display("FAIL %s: cyc=%0d got=%b want=%b (rst_all,rx_dp,done,ctr,latched,fail)",
                   x.nm, cyc - base, cur, x.v);
        end
      end else if (cur !== prev_v) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_change: cyc=%0d got=%b was=%b", cyc - base, cur, prev_v);
      end
    end
    prev_v = cur;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input int k, input string nm);
    exp_t x;
    x.cyc = base + k;
    x.v   = e;
    x.nm  = nm;
    exp_q.push_back(x);
  endtask

  task automatic wait_k(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  task automatic zero_inputs();
    gt_if.gtwiz_reset_tx_done_sync       = 1'b0;
    gt_if.gtwiz_reset_rx_done_sync       = 1'b0;
    gt_if.gtwiz_buffbypass_rx_done_sync  = 1'b0;
    gt_if.gtwiz_buffbypass_rx_error_sync = 1'b0;
    gt_if.link_status_in                 = 1'b0;
    gt_if.link_down_latched_reset_in     = 1'b0;
  endtask

  // Called on a negedge: one reset edge, then base = cycle stamp seen after that edge.
  task automatic do_reset();
    rst = 1'b1;
    zero_inputs();
    base = cyc + 1;
    e = '{reset_all: 1'b1, rx_dp: 1'b0, init_done: 1'b0, ctr: 4'd0, latched: 1'b0, fail: 1'b0};
    push(0, "reset_state");
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic end_test(input int k_last, input string nm);
    wait_k(k_last + 2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d expectations left, want 0", nm, exp_q.size());
    end
  endtask

  task automatic bring_up_inputs();
    wait_k(10);
    gt_if.gtwiz_reset_tx_done_sync = 1'b1;
    gt_if.gtwiz_reset_rx_done_sync = 1'b1;
    wait_k(15);
    gt_if.gtwiz_buffbypass_rx_done_sync = 1'b1;
    wait_k(20);
    gt_if.link_status_in = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    base     = 0;
    rst      = 1'b1;
    zero_inputs();
    repeat (3) @(negedge clk);

    // 1: happy path. WAIT_LINK entered at 16, link sampled from edge 21, 8th good edge = 28.
    do_reset();
    e.reset_all = 1'b0; push(P_PULSE, "t1_rst_all_pulse_end");
    e.init_done = 1'b1; push(20 + P_STB, "t1_init_done");
    bring_up_inputs();
    end_test(20 + P_STB, "t1");

    // 2: link glitch at 25 restarts qualification; 8 good edges 27..34.
    do_reset();
    e.reset_all = 1'b0; push(P_PULSE, "t2_rst_all_pulse_end");
    e.init_done = 1'b1; push(34, "t2_init_done_after_glitch");
    bring_up_inputs();
    wait_k(25); gt_if.link_status_in = 1'b0;
    wait_k(26); gt_if.link_status_in = 1'b1;
    wait_k(34);

    // 3: link loss in DONE, rx_datapath pulse, requalify, sticky latch, set-vs-clear, tx_done fall.
    e.rx_dp = 1'b1; e.init_done = 1'b0; e.latched = 1'b1; push(41, "t3_link_loss");
    e.rx_dp = 1'b0;                                       push(41 + P_PULSE, "t3_rx_dp_pulse_end");
    e.init_done = 1'b1;                                   push(47 + P_STB, "t3_requalified");
    e.latched = 1'b0;                                     push(61, "t3_latched_clear");
    e.rx_dp = 1'b1; e.init_done = 1'b0; e.latched = 1'b1; push(71, "t3_set_wins_over_clear");
    e.rx_dp = 1'b0;                                       push(71 + P_PULSE, "t3_rx_dp_pulse2_end");
    e.init_done = 1'b1;                                   push(77 + P_STB, "t3_requalified2");
    e.init_done = 1'b0;                                   push(101, "t3_tx_fall_retry");
`ifdef GT_INIT_AUTO_RETRY_EN
    e.reset_all = 1'b1; e.ctr = 4'd1;                     push(102, "t3_retry_to_rst_all");
    e.reset_all = 1'b0;                                   push(102 + P_PULSE, "t3_rst_all_end");
`else
    e.ctr = 4'd1; e.fail = 1'b1;                          push(102, "t3_retry_to_fail");
`endif
    wait_k(40); gt_if.link_status_in = 1'b0;
    wait_k(41); gt_if.link_status_in = 1'b1;
    wait_k(60); gt_if.link_down_latched_reset_in = 1'b1;
    wait_k(61); gt_if.link_down_latched_reset_in = 1'b0;
    wait_k(70); gt_if.link_status_in = 1'b0; gt_if.link_down_latched_reset_in = 1'b1;
    wait_k(71); gt_if.link_status_in = 1'b1; gt_if.link_down_latched_reset_in = 1'b0;
    wait_k(100); gt_if.gtwiz_reset_tx_done_sync = 1'b0;
    end_test(106, "t3");

`ifdef GT_INIT_AUTO_RETRY_EN
    // 4: tx_done never comes; 17 timeouts, counter saturates at 15.
    do_reset();
    e.reset_all = 1'b0; push(P_PULSE, "t4_rst_all_pulse_end");
    for (int n = 1; n <= 17; n++) begin
      e.reset_all = 1'b1;
      e.ctr = (n > 15) ? 4'd15 : 4'(n);
      push(n * C_RETRY_PERIOD, "t4_timeout_retry");
      e.reset_all = 1'b0;
      push(n * C_RETRY_PERIOD + P_PULSE, "t4_rst_all_pulse_end");
    end
    end_test(17 * C_RETRY_PERIOD + P_PULSE, "t4");
`endif

    // 5: bb_error and bb_done together in WAIT_BB -> RETRY (error has priority).
    do_reset();
    e.reset_all = 1'b0; push(P_PULSE, "t5_rst_all_pulse_end");
`ifdef GT_INIT_AUTO_RETRY_EN
    e.reset_all = 1'b1; e.ctr = 4'd1; push(17, "t5_bb_error_retry");
    e.reset_all = 1'b0;               push(17 + P_PULSE, "t5_rst_all_pulse_end2");
`else
    e.ctr = 4'd1; e.fail = 1'b1;      push(17, "t5_bb_error_fail");
`endif
    wait_k(10);
    gt_if.gtwiz_reset_tx_done_sync = 1'b1;
    gt_if.gtwiz_reset_rx_done_sync = 1'b1;
    wait_k(15);
    gt_if.gtwiz_buffbypass_rx_done_sync  = 1'b1;
    gt_if.gtwiz_buffbypass_rx_error_sync = 1'b1;
    wait_k(16);
    gt_if.gtwiz_buffbypass_rx_done_sync  = 1'b0;
    gt_if.gtwiz_buffbypass_rx_error_sync = 1'b0;
    end_test(21, "t5");

`ifndef GT_INIT_AUTO_RETRY_EN
    // 6: one timeout -> FAIL held; reset from FAIL and from mid-WAIT_LINK.
    do_reset();
    e.reset_all = 1'b0;          push(P_PULSE, "t6_rst_all_pulse_end");
    e.ctr = 4'd1; e.fail = 1'b1; push(C_RETRY_PERIOD, "t6_timeout_fail");
    push(C_RETRY_PERIOD + 1000, "t6_fail_held");
    end_test(C_RETRY_PERIOD + 1000, "t6a");
    do_reset();
    e.reset_all = 1'b0; push(P_PULSE, "t6_rst_all_pulse_end2");
    bring_up_inputs();
    wait_k(24);
    do_reset();
    e.reset_all = 1'b0; push(P_PULSE, "t6_rst_all_pulse_end3");
    e.init_done = 1'b1; push(20 + P_STB, "t6_init_done_after_reset");
    bring_up_inputs();
    end_test(20 + P_STB, "t6b");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
